ps2_key_state_tracker: RTL and testbench

Parametrised PS/2 scancode-to-key-state tracker that sits between the PS/2 byte receiver and the note/voice logic. It consumes one received scancode byte per strobe and decodes make, break and extended prefixes with a small FSM. It maintains a per-key held-state vector and a held-key count, and pushes press/release events into a show-ahead event FIFO. Auto-repeat makes and stray breaks are filtered out, so downstream note logic sees exactly one press and one release per physical keystroke.

---
 rtl/ps2_key_state_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_state_tracker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_state_tracker.sv
// ps2_key_state_tracker
// Turns a stream of PS/2 scancode bytes into a per-key held-state vector,
// a held-key count and a show-ahead FIFO of press/release events.
// Typematic repeats and breaks of keys that are not held produce nothing,
// so each physical keystroke yields exactly one press and one release.
// Optional feature macro: EXTENDED_KEYS_EN (decode the 0xE0 prefix and
// widen the key space to 512 entries indexed by {ext, code}).
module ps2_key_state_tracker #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 10,
`ifdef EXTENDED_KEYS_EN
    localparam int KEY_STATE_W = 512
`else
    localparam int KEY_STATE_W = 256
`endif
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   recievedNewData,
    input  logic [7:0]             newData,
    input  logic                   clearAll,
    output logic [KEY_STATE_W-1:0] inputStateStorage,
    output logic [CNT_W-1:0]       heldCount,
    output logic                   eventValid,
    output logic [9:0]             eventData,
    input  logic                   eventReady,
    output logic                   overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = $clog2(KEY_STATE_W);

`ifdef EXTENDED_KEYS_EN
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parse_state_t;
`else
    typedef enum logic [0:0] {IDLE, BRK} parse_state_t;
`endif

    parse_state_t state_reg;

    logic [KEY_STATE_W-1:0] state_vec_reg;
    logic [CNT_W-1:0]       held_cnt_reg;

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [9:0]    head_reg;
    logic [9:0]    head_next;
    logic          overflow_reg;

    logic is_f0;
    logic is_e0;
    logic is_nonkey;
    logic is_key;
    logic key_strobe;
    logic key_brk;
    logic key_ext;
    logic [IDX_W-1:0] key_idx;
    logic key_held;
    logic do_set;
    logic do_clr;
    logic push_req;
    logic [9:0] push_data;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Classify the incoming byte: prefixes, protocol/non-key bytes, key codes.
    always_comb begin
        is_f0 = (newData == 8'hF0);
        is_e0 = (newData == 8'hE0);
        case (newData)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_nonkey = 1'b1;
            default:                    is_nonkey = 1'b0;
        endcase
        // Without extended decoding 0xE0 is neither prefix nor key: it is ignored.
        is_key = !is_f0 && !is_e0 && !is_nonkey;
    end

    // Decide what a key byte means given the pending prefixes, and whether
    // it changes the held state (repeats and stray breaks are filtered here).
    always_comb begin
        key_strobe = recievedNewData && !clearAll && is_key;
`ifdef EXTENDED_KEYS_EN
        key_brk = (state_reg == BRK) || (state_reg == EXT_BRK);
        key_ext = (state_reg == EXT) || (state_reg == EXT_BRK);
        key_idx = {key_ext, newData};
`else
        key_brk = (state_reg == BRK);
        key_ext = 1'b0;
        key_idx = newData;
`endif
        key_held  = state_vec_reg[key_idx];
        do_set    = key_strobe && !key_brk && !key_held;
        do_clr    = key_strobe && key_brk && key_held;
        push_req  = do_set || do_clr;
        push_data = {do_set, key_ext, newData};
    end

    // Prefix parser: remembers pending break/extended prefixes between bytes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else if (clearAll) begin
            state_reg <= IDLE;
        end else if (recievedNewData) begin
            case (state_reg)
`ifdef EXTENDED_KEYS_EN
                IDLE: begin
                    if (is_f0)      state_reg <= BRK;
                    else if (is_e0) state_reg <= EXT;
                    else            state_reg <= IDLE;
                end
                BRK: begin
                    if (is_f0)      state_reg <= BRK;
                    else if (is_e0) state_reg <= EXT_BRK;
                    else            state_reg <= IDLE;
                end
                EXT: begin
                    if (is_f0)      state_reg <= EXT_BRK;
                    else if (is_e0) state_reg <= EXT;
                    else            state_reg <= IDLE;
                end
                EXT_BRK: begin
                    // Repeated prefixes keep the extended break pending.
                    if (is_f0 || is_e0) state_reg <= EXT_BRK;
                    else                state_reg <= IDLE;
                end
`else
                IDLE: begin
                    if (is_f0) state_reg <= BRK;
                    else       state_reg <= IDLE;
                end
                BRK: begin
                    // 0xE0 is transparent here so that E0 F0 xx acts as F0 xx.
                    if (is_f0 || is_e0) state_reg <= BRK;
                    else                state_reg <= IDLE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Held-key vector and count move together so the count always matches.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_vec_reg <= '0;
            held_cnt_reg  <= '0;
        end else if (clearAll) begin
            state_vec_reg <= '0;
            held_cnt_reg  <= '0;
        end else if (do_set) begin
            state_vec_reg[key_idx] <= 1'b1;
            held_cnt_reg           <= held_cnt_reg + CNT_W'(1);
        end else if (do_clr) begin
            state_vec_reg[key_idx] <= 1'b0;
            held_cnt_reg           <= held_cnt_reg - CNT_W'(1);
        end
    end

    // FIFO control: a pop in the same cycle frees the slot a full push needs.
    always_comb begin
        pop     = eventReady && (count_reg != '0) && !clearAll;
        full    = (count_reg == (AW+1)'(FIFO_DEPTH));
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;

        // The head is kept in a register so eventData holds when the FIFO empties.
        head_next = head_reg;
        if (count_reg == '0) begin
            if (push_ok) head_next = push_data;
        end else if (pop) begin
            if (count_reg > (AW+1)'(1)) head_next = mem[rd_ptr_reg + AW'(1)];
            else if (push_ok)           head_next = push_data;
        end
    end

    // Event storage array; written only, read through the head register.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    // FIFO pointers, occupancy, head register and sticky overflow.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (clearAll) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_ok && !pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (pop && !push_ok) count_reg <= count_reg - (AW+1)'(1);
            head_reg <= head_next;
            if (drop) overflow_reg <= 1'b1;
        end
    end

    assign inputStateStorage = state_vec_reg;
    assign heldCount         = held_cnt_reg;
    assign eventValid        = (count_reg != '0);
    assign eventData         = head_reg;
    assign overflow          = overflow_reg;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Testbench for ps2_key_state_tracker: directed scenarios followed by random
// byte traffic, all checked cycle by cycle against a prefix/queue model.
module tb_ps2_key_state_tracker;

    localparam int DEPTH = 8;
    localparam int CW    = 10;
`ifdef EXTENDED_KEYS_EN
    localparam int KW    = 512;
    localparam bit EXT_EN = 1'b1;
`else
    localparam int KW    = 256;
    localparam bit EXT_EN = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic          recievedNewData;
    logic [7:0]    newData;
    logic          clearAll;
    logic [KW-1:0] inputStateStorage;
    logic [CW-1:0] heldCount;
    logic          eventValid;
    logic [9:0]    eventData;
    logic          eventReady;
    logic          overflow;

    ps2_key_state_tracker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLOCK_50          (CLOCK_50),
        .resetn            (resetn),
        .recievedNewData   (recievedNewData),
        .newData           (newData),
        .clearAll          (clearAll),
        .inputStateStorage (inputStateStorage),
        .heldCount         (heldCount),
        .eventValid        (eventValid),
        .eventData         (eventData),
        .eventReady        (eventReady),
        .overflow          (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending-prefix flags, held set, event queue.
    logic [KW-1:0] m_vec;
    int            m_cnt;
    logic [9:0]    m_q[$];
    bit            m_ovf;
    bit            m_brk_pending;
    bit            m_ext_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vec = '0;
        m_cnt = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_brk_pending = 1'b0;
        m_ext_pending = 1'b0;
    endtask

    task automatic model_step(input bit s, input logic [7:0] b, input bit r, input bit c);
        bit have_evt;
        logic [9:0] evt;
        int idx;
        have_evt = 1'b0;
        evt = '0;
        if (c) begin
            model_reset();
            return;
        end
        if (s) begin
            if (b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
                m_brk_pending = 1'b0;
                m_ext_pending = 1'b0;
            end else if (b == 8'hF0) begin
                m_brk_pending = 1'b1;
            end else if (b == 8'hE0) begin
                if (EXT_EN) m_ext_pending = 1'b1;
            end else begin
                idx = (m_ext_pending ? 256 : 0) + int'(b);
                if (!m_brk_pending && !m_vec[idx]) begin
                    m_vec[idx] = 1'b1;
                    m_cnt++;
                    have_evt = 1'b1;
                    evt = {1'b1, m_ext_pending, b};
                end else if (m_brk_pending && m_vec[idx]) begin
                    m_vec[idx] = 1'b0;
                    m_cnt--;
                    have_evt = 1'b1;
                    evt = {1'b0, m_ext_pending, b};
                end
                m_brk_pending = 1'b0;
                m_ext_pending = 1'b0;
            end
        end
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (have_evt) begin
            if (m_q.size() < DEPTH) m_q.push_back(evt);
            else                    m_ovf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":heldCount"}, 32'(heldCount), 32'(m_cnt));
        chk({tag, ":eventValid"}, 32'(eventValid), 32'(m_q.size() > 0));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) chk({tag, ":eventData"}, 32'(eventData), 32'(m_q[0]));
        n_checks++;
        assert (inputStateStorage === m_vec) else begin
            n_fail++;
            $error("FAIL %s:vector observed=%h expected=%h", tag, inputStateStorage, m_vec);
        end
    endtask

    task automatic step(input string tag, input bit s, input logic [7:0] b, input bit r, input bit c);
        recievedNewData = s;
        newData         = b;
        eventReady      = r;
        clearAll        = c;
        model_step(s, b, r, c);
        @(posedge CLOCK_50);
        #1;
        check_all(tag);
    endtask

    task automatic byte_in(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        recievedNewData = 1'b0;
        newData = 8'h00;
        eventReady = 1'b0;
        clearAll = 1'b0;
        model_reset();
        @(posedge CLOCK_50);
        #1;
        check_all("reset");
        chk("reset:eventData", 32'(eventData), 32'h0);
        resetn = 1'b1;
    endtask

    initial begin
        logic [7:0] nk_tab [9];
        nk_tab = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

        do_reset();

        // Spacebar with typematic repeat: one press event only.
        byte_in("space1", 8'h29);
        byte_in("space2", 8'h29);
        byte_in("space3", 8'h29);
        chk("space:bit", 32'(inputStateStorage[8'h29]), 32'h1);
        chk("space:count", 32'(heldCount), 32'h1);
        chk("space:event", 32'(eventData), 32'h229);
        pop_one("space_pop");
        chk("space:one_event", 32'(eventValid), 32'h0);

        // Release, then a stray second release.
        byte_in("rel_f0", 8'hF0);
        byte_in("rel_29", 8'h29);
        chk("rel:event", 32'(eventData), 32'h029);
        chk("rel:count", 32'(heldCount), 32'h0);
        pop_one("rel_pop");
        byte_in("stray_f0", 8'hF0);
        byte_in("stray_29", 8'h29);
        chk("stray:no_event", 32'(eventValid), 32'h0);

        // Extended key press and release (plain break without extension support).
        byte_in("ext_e0", 8'hE0);
        byte_in("ext_75", 8'h75);
        chk("ext:press", 32'(eventData), EXT_EN ? 32'h375 : 32'h275);
        byte_in("ext_e0b", 8'hE0);
        byte_in("ext_f0", 8'hF0);
        byte_in("ext_75b", 8'h75);
        pop_one("ext_pop1");
        chk("ext:release", 32'(eventData), EXT_EN ? 32'h175 : 32'h075);
        pop_one("ext_pop2");

        // Overflow: nine makes into an eight-entry FIFO, then drain.
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) byte_in("ovf_make", 8'(8'h15 + i));
        chk("ovf:flag", 32'(overflow), 32'h1);
        chk("ovf:count", 32'(heldCount), 32'h9);
        for (int i = 0; i < 8; i++) begin
            chk("ovf:drain", 32'(eventData), 32'(10'h215 + i));
            pop_one("ovf_pop");
        end
        chk("ovf:empty", 32'(eventValid), 32'h0);

        // Non-key byte cancels a pending break.
        step("aa_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        byte_in("aa_f0", 8'hF0);
        byte_in("aa_aa", 8'hAA);
        byte_in("aa_5d", 8'h5D);
        chk("aa:make", 32'(eventData), 32'h25D);

        // clearAll with three keys held.
        byte_in("cl_1c", 8'h1C);
        byte_in("cl_1b", 8'h1B);
        byte_in("cl_23", 8'h23);
        step("cl_clear", 1'b1, 8'h2B, 1'b0, 1'b1);
        chk("cl:vec_zero", 32'(inputStateStorage == '0), 32'h1);
        chk("cl:count", 32'(heldCount), 32'h0);
        chk("cl:valid", 32'(eventValid), 32'h0);
        chk("cl:ovf", 32'(overflow), 32'h0);
        byte_in("cl_29", 8'h29);
        chk("cl:next", 32'(eventData), 32'h229);

        // Reset in the middle of a break sequence forgets the prefix.
        pop_one("rs_pop");
        byte_in("rs_f0", 8'hF0);
        do_reset();
        byte_in("rs_29", 8'h29);
        chk("rs:make", 32'(eventData), 32'h229);
        chk("rs:count", 32'(heldCount), 32'h1);

        // Random traffic with random pops and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hF0;
            else if (r < 20) b = 8'hE0;
            else if (r < 25) b = nk_tab[$urandom_range(0, 8)];
            else if (r < 30) b = 8'h75;
            else             b = 8'(8'h10 + $urandom_range(0, 15));
            step("rand", ($urandom_range(0, 9) < 8), b, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
